// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped word cache: geometry, controller states and
// address field helpers used by both the cache and CPU-side address logic.
package cache_pkg;

    localparam int unsigned DEF_ADDR_W     = 16;
    localparam int unsigned DEF_WORD_W     = 16;
    localparam int unsigned DEF_NUM_LINES  = 8;
    localparam int unsigned DEF_LINE_WORDS = 4;
    localparam int unsigned DEF_CNT_W      = 16;

    localparam int unsigned OFF_B = $clog2(DEF_LINE_WORDS);
    localparam int unsigned IDX_B = $clog2(DEF_NUM_LINES);
    // Bit 0 selects a byte within a word and is never part of the tag.
    localparam int unsigned TAG_B = DEF_ADDR_W - IDX_B - OFF_B - 1;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StRefill,
        StWrite,
        StResp
    } state_e;

    typedef logic [DEF_ADDR_W-1:0] addr_t;
    typedef logic [OFF_B-1:0]      offset_t;
    typedef logic [IDX_B-1:0]      index_t;
    typedef logic [TAG_B-1:0]      tag_t;

    function automatic offset_t addr_offset(input addr_t a);
        return a[OFF_B:1];
    endfunction

    function automatic index_t addr_index(input addr_t a);
        return a[OFF_B+IDX_B:OFF_B+1];
    endfunction

    function automatic tag_t addr_tag(input addr_t a);
        return a[DEF_ADDR_W-1:OFF_B+IDX_B+1];
    endfunction

    function automatic addr_t line_word_addr(input tag_t t, input index_t i, input offset_t o);
        return {t, i, o, 1'b0};
    endfunction

endpackage

// File: rtl/cache_tag_data_array.sv
// Valid/tag/data storage for the direct-mapped cache: combinational read port, single
// synchronous write port and a flush that clears every valid bit.
module cache_tag_data_array #(
    parameter int unsigned WORD_W     = 16,
    parameter int unsigned NUM_LINES  = 8,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned TAG_W      = 10,
    parameter int unsigned IDX_W      = $clog2(NUM_LINES),
    parameter int unsigned OFF_W      = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [OFF_W-1:0]  rd_off,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [WORD_W-1:0] rd_data,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [OFF_W-1:0]  wr_off,
    input  logic              wr_tag_en,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic              wr_valid_en,
    input  logic              wr_valid,
    input  logic              wr_data_en,
    input  logic [WORD_W-1:0] wr_data
);

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [TAG_W-1:0]     tag_d  [NUM_LINES];
    logic [WORD_W-1:0]    data_q [NUM_LINES][LINE_WORDS];
    logic [WORD_W-1:0]    data_d [NUM_LINES][LINE_WORDS];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx][rd_off];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_valid_en) valid_d[wr_idx] = wr_valid;
        if (wr_tag_en)   tag_d[wr_idx] = wr_tag;
        if (wr_data_en)  data_d[wr_idx][wr_off] = wr_data;
        // Flush takes priority so a same-cycle write cannot resurrect a line.
        if (flush)       valid_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/direct_mapped_cache.sv
// Direct-mapped, write-through, no-write-allocate word cache. One outstanding CPU request;
// read misses refill the whole line, every write is forwarded to memory.
module direct_mapped_cache
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned WORD_W     = DEF_WORD_W,
    parameter int unsigned NUM_LINES  = DEF_NUM_LINES,
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam offset_t LastOff = offset_t'(LINE_WORDS - 1);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    offset_t           cnt_q, cnt_d;
    logic              resp_valid_q, resp_valid_d;
    logic [WORD_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]  hit_q, hit_d;
    logic [CNT_W-1:0]  miss_q, miss_d;

    logic              arr_flush;
    logic              rd_valid;
    tag_t              rd_tag;
    logic [WORD_W-1:0] rd_data;
    offset_t           wr_off;
    logic              wr_tag_en;
    logic              wr_valid_en;
    logic              wr_valid;
    logic              wr_data_en;
    logic [WORD_W-1:0] wr_data;

    tag_t    req_tag;
    index_t  req_idx;
    offset_t req_off;
    logic    line_hit;

    assign req_tag  = addr_tag(addr_q);
    assign req_idx  = addr_index(addr_q);
    assign req_off  = addr_offset(addr_q);
    assign line_hit = rd_valid && (rd_tag == req_tag);

    cache_tag_data_array #(
        .WORD_W     (WORD_W),
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_B)
    ) u_array (
        .clk         (clk),
        .rst         (rst),
        .flush       (arr_flush),
        .rd_idx      (req_idx),
        .rd_off      (req_off),
        .rd_valid    (rd_valid),
        .rd_tag      (rd_tag),
        .rd_data     (rd_data),
        .wr_idx      (req_idx),
        .wr_off      (wr_off),
        .wr_tag_en   (wr_tag_en),
        .wr_tag      (req_tag),
        .wr_valid_en (wr_valid_en),
        .wr_valid    (wr_valid),
        .wr_data_en  (wr_data_en),
        .wr_data     (wr_data)
    );

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        hit_d        = hit_q;
        miss_d       = miss_q;
        req_ready    = 1'b0;
        arr_flush    = 1'b0;
        wr_off       = req_off;
        wr_tag_en    = 1'b0;
        wr_valid_en  = 1'b0;
        wr_valid     = 1'b0;
        wr_data_en   = 1'b0;
        wr_data      = wdata_q;

        unique case (state_q)
            StIdle: begin
                // A flush blocks acceptance for the cycle it is honoured.
                req_ready = !flush;
                if (flush) begin
                    arr_flush = 1'b1;
                end else if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr & ~{{(ADDR_W-1){1'b0}}, 1'b1};
                    wdata_d = req_wdata;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (we_q) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = wdata_q;
                    state_d     = StWrite;
                end else if (line_hit) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = rd_data;
                    if (hit_q != '1) hit_d = hit_q + 1'b1;
                    state_d = StIdle;
                end else begin
                    if (miss_q != '1) miss_d = miss_q + 1'b1;
                    // Line stays invalid until the last refill word lands.
                    wr_tag_en   = 1'b1;
                    wr_valid_en = 1'b1;
                    wr_valid    = 1'b0;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = line_word_addr(req_tag, req_idx, '0);
                    state_d     = StRefill;
                end
            end
            StRefill: begin
                if (mem_ack) begin
                    wr_data_en = 1'b1;
                    wr_off     = cnt_q;
                    wr_data    = mem_rdata;
                    if (cnt_q == req_off) resp_rdata_d = mem_rdata;
                    if (cnt_q == LastOff) begin
                        wr_valid_en = 1'b1;
                        wr_valid    = 1'b1;
                        mem_req_d   = 1'b0;
                        state_d     = StResp;
                    end else begin
                        cnt_d      = cnt_q + 1'b1;
                        mem_addr_d = line_word_addr(req_tag, req_idx, cnt_q + 1'b1);
                    end
                end
            end
            StWrite: begin
                if (mem_ack) begin
                    wr_data_en   = line_hit;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = StIdle;
                end
            end
            StResp: begin
                resp_valid_d = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            hit_q        <= '0;
            miss_q       <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;

endmodule

// File: doc/direct_mapped_cache.md
Name: direct_mapped_cache

Overview:
- Direct-mapped, write-through, no-write-allocate word cache between the CPU's memory-access stages (instruction fetch and execute/memory) and the 64 KiB byte-addressed main memory.
- Accepts one 16-bit word request at a time from the CPU.
- Serves read hits in one cycle; refills a full line from memory on a read miss.
- Forwards every write to memory.

Parameters:
- ADDR_W, 16, byte-address width.
- WORD_W, 16, data word width.
- NUM_LINES, 8, number of cache lines (power of 2).
- LINE_WORDS, 4, words per line (power of 2).
- CNT_W, 16, width of hit/miss counters.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  CPU request present
- req_ready  out  1  cache can accept a request (high only in IDLE)
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address; bit 0 ignored (word aligned)
- req_wdata  in  WORD_W  write data
- resp_valid  out  1  one-cycle pulse: read data valid / write complete
- resp_rdata  out  WORD_W  read data (held until next resp_valid)
- flush  in  1  invalidate all lines; honoured only in IDLE
- mem_req  out  1  memory access request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  word-aligned byte address to memory
- mem_wdata  out  WORD_W  memory write data
- mem_ack  in  1  memory completes the current access this cycle
- mem_rdata  in  WORD_W  memory read data, valid with mem_ack
- hit_count  out  CNT_W  saturating read-hit counter
- miss_count  out  CNT_W  saturating read-miss counter

Behaviour:
- Address split: offset = addr[OFF_B:1], OFF_B = log2(LINE_WORDS); index = next log2(NUM_LINES) bits; tag = remaining upper bits.
- Storage: valid bit and tag per line; data array NUM_LINES x LINE_WORDS x WORD_W. Data array is not reset.
- Reset (async): state=IDLE; all valid=0; req_ready=1; resp_valid=0; resp_rdata=0; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; both counters=0. Reset mid-refill or mid-write abandons the access; the line is left invalid.
- Request acceptance: on req_valid && req_ready, latch we/addr/wdata. Inputs are ignored in all other states.
- State IDLE:
  - flush=1 with no accepted request: clear all valid bits this cycle; stay in IDLE.
  - flush and req_valid both high: the flush wins; the request is not accepted (req_ready=0 that cycle).
  - Request accepted: go to LOOKUP.
- State LOOKUP:
  - Read hit: resp_rdata = line word; resp_valid=1; hit_count++; go to IDLE. Accept-to-response latency is 2 cycles.
  - Read miss: miss_count++; clear the line's valid bit; write the new tag; word counter=0; go to REFILL.
  - Write: drive mem_req=1, mem_we=1, mem_addr, mem_wdata; go to WRITE.
- State REFILL:
  - mem_req=1, mem_we=0, mem_addr = {tag, index, counter, 1'b0}.
  - On mem_ack: store mem_rdata at counter. If counter equals the requested offset, also capture it into resp_rdata.
  - After the last word's ack: set valid, go to RESP.
- State WRITE:
  - Hold the request until mem_ack.
  - On mem_ack: if the line is valid and the tag matches, update the cached word. Then drop mem_req and mem_we, pulse resp_valid, go to IDLE.
- State RESP: resp_valid=1; go to IDLE.
- mem_req drops in the cycle after the final ack. mem_req never issues back-to-back without re-evaluating mem_addr.
- Counters saturate at all-ones; writes count neither hit nor miss.
- Unbounded memory latency is allowed; the design contains no timeout.

Decomposition:
- Shared cache_pkg holds:
  - the state encoding (IDLE, LOOKUP, REFILL, WRITE, RESP);
  - localparams OFF_B, IDX_B, TAG_B derived from the parameters;
  - the tag/index/offset extraction functions, so the CPU-side address helpers reuse them.
- One natural sub-module, cache_tag_data_array: valid/tag/data storage with one read port, one write port and a flush-all input.
- The controller FSM and counters live in direct_mapped_cache.

Test Plan:
- Reset, then read 0x0010 with memory words 0x0010..0x0016 = 0xA000..0xA003 -> one miss, 4 mem reads at 0x0010, 0x0012, 0x0014, 0x0016; resp_rdata=0xA000; miss_count=1.
- Re-read 0x0014 after the refill -> no mem_req; resp_valid 2 cycles after accept; resp_rdata=0xA002; hit_count=1.
- Write 0x0012 = 0xBEEF (line cached), mem_ack delayed 3 cycles -> one mem write at 0x0012; req_ready low until the ack; a subsequent read of 0x0012 hits and returns 0xBEEF.
- Write 0x0200 = 0x1234 (uncached) -> mem write issued, no allocate; a read of 0x0200 is a miss (miss_count increments).
- Read 0x0010 (hit), assert flush in IDLE, read 0x0010 again -> miss with a 4-word refill; a request asserted together with flush is not accepted.
- Assert rst during the 2nd refill ack wait -> all outputs return to reset values; a read of the same address misses again.
